// File: rtl/sync_fifo_pkg.sv
// Shared defaults and helpers for the single-clock FIFO.
// Read mode is selected at compile time by SYNC_FIFO_FWFT_EN (see sync_fifo_mem).
package sync_fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 41;
  localparam int DEFAULT_ADDR_WIDTH = 4;

  // Pointers carry one extra wrap bit; the caller truncates the 32-bit
  // difference to ADDR_WIDTH+1 bits, which yields the modulo occupancy.
  function automatic logic [31:0] calc_level(input logic [31:0] wr_ptr,
                                             input logic [31:0] rd_ptr);
    return wr_ptr - rd_ptr;
  endfunction

  function automatic bit thresh_ok(input int afull_thresh,
                                   input int aempty_thresh,
                                   input int addr_width);
    int depth;
    depth = 1 << addr_width;
    return (afull_thresh >= 1) && (afull_thresh <= depth) &&
           (aempty_thresh >= 0) && (aempty_thresh <= depth - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Storage array for sync_fifo_ctrl: one write port, one read port, no reset on storage.
// SYNC_FIFO_FWFT_EN defined: combinational read; undefined: registered read.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is presented directly; the pop only advances the pointer upstream.
  logic unused_rd_ctrl;
  assign unused_rd_ctrl = &{1'b0, rst_n, rd_en};
  assign rd_data        = mem_q[rd_addr];
`else
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [DATA_WIDTH-1:0] rd_data_d;

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem_q[rd_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;
`endif

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO: pointers, level, threshold flags, sticky errors, flush.
// Read mode chosen by SYNC_FIFO_FWFT_EN (first-word-fall-through when defined).
module sync_fifo_ctrl
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH    = DEFAULT_ADDR_WIDTH,
  parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 2,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   level,
  input  logic                  err_clr,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [PW-1:0] LVL_FULL   = PW'(DEPTH);
  localparam logic [PW-1:0] LVL_AFULL  = PW'(AFULL_THRESH);
  localparam logic [PW-1:0] LVL_AEMPTY = PW'(AEMPTY_THRESH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic [PW-1:0] level_w;
  logic          full_w, empty_w;
  logic          wr_acc, rd_acc, wr_rej, rd_rej;

  assign level_w = PW'(calc_level(32'(wr_ptr_q), 32'(rd_ptr_q)));
  assign full_w  = (level_w == LVL_FULL);
  assign empty_w = (level_w == '0);

  // Flush masks both requests so neither moves a pointer nor raises an error.
  always_comb begin
    wr_acc      = 1'b0;
    rd_acc      = 1'b0;
    wr_rej      = 1'b0;
    rd_rej      = 1'b0;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      wr_acc   = wr_en && !full_w;
      rd_acc   = rd_en && !empty_w;
      wr_rej   = wr_en && full_w;
      rd_rej   = rd_en && empty_w;
      wr_ptr_d = wr_ptr_q + {{ADDR_WIDTH{1'b0}}, wr_acc};
      rd_ptr_d = rd_ptr_q + {{ADDR_WIDTH{1'b0}}, rd_acc};
    end

    if (err_clr) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (wr_rej) begin
      overflow_d = 1'b1;
    end
    if (rd_rej) begin
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wr_data (wr_data),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rd_data (rd_data)
  );

  assign level        = level_w;
  assign full         = full_w;
  assign empty        = empty_w;
  assign almost_full  = (level_w >= LVL_AFULL);
  assign almost_empty = (level_w <= LVL_AEMPTY);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed table-driven bench for sync_fifo_ctrl (works with or without SYNC_FIFO_FWFT_EN).
module tb_sync_fifo_ctrl;
  import sync_fifo_pkg::*;

  localparam int DW    = 41;
  localparam int AW    = 4;
  localparam int AF    = 14;
  localparam int AE    = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic          err_clr = 1'b0;
  logic [DW-1:0] rd_data;
  logic          full, empty, almost_full, almost_empty, overflow, underflow;
  logic [AW:0]   level;

  sync_fifo_ctrl #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .AFULL_THRESH  (AF),
    .AEMPTY_THRESH (AE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (clr),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .level        (level),
    .err_clr      (err_clr),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          clr, wr, rd, eclr;
    logic [DW-1:0] wdata;
    logic          pop;
    logic [DW-1:0] pdata;
    logic [AW:0]   lvl;
    logic          full, empty, af, ae, ovf, unf;
  } vec_t;

  vec_t          vecs[$];
  int            n_checks = 0;
  int            n_fail = 0;
  logic [DW-1:0] last_pop = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Flags are derived from the expected level using the bench's own thresholds.
  function automatic vec_t mk(input logic c, input logic w, input logic [DW-1:0] wd,
                              input logic r, input logic e, input logic p,
                              input logic [DW-1:0] pd, input int lv,
                              input logic ov, input logic un);
    vec_t v;
    v.clr = c; v.wr = w; v.wdata = wd; v.rd = r; v.eclr = e;
    v.pop = p; v.pdata = pd; v.lvl = (AW+1)'(lv);
    v.full  = (lv == 16);
    v.empty = (lv == 0);
    v.af    = (lv >= 14);
    v.ae    = (lv <= 1);
    v.ovf = ov; v.unf = un;
    return v;
  endfunction

  task automatic apply(input vec_t v, input int idx);
    clr = v.clr; wr_en = v.wr; wr_data = v.wdata; rd_en = v.rd; err_clr = v.eclr;
`ifdef SYNC_FIFO_FWFT_EN
    if (v.pop) chk($sformatf("v%0d head", idx), 64'(rd_data), 64'(v.pdata));
`endif
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
    if (v.pop) last_pop = v.pdata;
    chk($sformatf("v%0d level", idx), 64'(level), 64'(v.lvl));
    chk($sformatf("v%0d full", idx), 64'(full), 64'(v.full));
    chk($sformatf("v%0d empty", idx), 64'(empty), 64'(v.empty));
    chk($sformatf("v%0d almost_full", idx), 64'(almost_full), 64'(v.af));
    chk($sformatf("v%0d almost_empty", idx), 64'(almost_empty), 64'(v.ae));
    chk($sformatf("v%0d overflow", idx), 64'(overflow), 64'(v.ovf));
    chk($sformatf("v%0d underflow", idx), 64'(underflow), 64'(v.unf));
`ifndef SYNC_FIFO_FWFT_EN
    chk($sformatf("v%0d rd_data", idx), 64'(rd_data), 64'(last_pop));
`endif
  endtask

  initial begin
    logic [DW-1:0] d;
    vec_t          v;

    assert (thresh_ok(AF, AE, AW)) else $error("threshold parameters out of range");

    // fill 1..16, then a rejected 17th write
    for (int i = 1; i <= 16; i++) vecs.push_back(mk(0, 1, DW'(i), 0, 0, 0, '0, i, 0, 0));
    vecs.push_back(mk(0, 1, DW'(17), 0, 0, 0, '0, 16, 1, 0));
    vecs.push_back(mk(0, 0, '0, 0, 1, 0, '0, 16, 0, 0));
    // drain in order, then a rejected read
    for (int i = 1; i <= 16; i++) vecs.push_back(mk(0, 0, '0, 1, 0, 1, DW'(i), 16 - i, 0, 0));
    vecs.push_back(mk(0, 0, '0, 1, 0, 0, '0, 0, 0, 1));
    vecs.push_back(mk(0, 0, '0, 0, 1, 0, '0, 0, 0, 0));
    // both requests while empty: write wins, read rejected
    vecs.push_back(mk(0, 1, DW'(32), 1, 0, 0, '0, 1, 0, 1));
    for (int i = 1; i <= 15; i++) vecs.push_back(mk(0, 1, DW'(32 + i), 0, 0, 0, '0, 1 + i, 0, 1));
    // both requests while full: read wins, write rejected
    vecs.push_back(mk(0, 1, DW'(48), 1, 0, 1, DW'(32), 15, 1, 1));
    vecs.push_back(mk(0, 0, '0, 0, 1, 0, '0, 15, 0, 0));
    for (int i = 0; i < 10; i++) vecs.push_back(mk(0, 0, '0, 1, 0, 1, DW'(33 + i), 14 - i, 0, 0));
    // both requests at level 5: level unchanged
    vecs.push_back(mk(0, 1, DW'(49), 1, 0, 1, DW'(43), 5, 0, 0));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 1, DW'(80 + i), 0, 0, 0, '0, 6 + i, 0, 0));
    // flush at level 9 with a write, then flush with a read at empty
    vecs.push_back(mk(1, 1, DW'(119), 0, 0, 0, '0, 0, 0, 0));
    vecs.push_back(mk(1, 0, '0, 1, 0, 0, '0, 0, 0, 0));
    // err_clr colliding with a rejected read: set wins
    vecs.push_back(mk(0, 0, '0, 1, 1, 0, '0, 0, 0, 1));
    vecs.push_back(mk(0, 0, '0, 0, 1, 0, '0, 0, 0, 0));
    // 40 write/read pairs wrap the pointers several times
    for (int k = 0; k < 40; k++) begin
      d = 41'h100_0000_0000 | DW'(k * 3 + 1);
      vecs.push_back(mk(0, 1, d, 0, 0, 0, '0, 1, 0, 0));
      vecs.push_back(mk(0, 0, '0, 1, 0, 1, d, 0, 0, 0));
    end

    // reset and idle
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset level", 64'(level), 64'(0));
    chk("reset empty", 64'(empty), 64'(1));
    chk("reset almost_empty", 64'(almost_empty), 64'(1));
    chk("reset full", 64'(full), 64'(0));
    chk("reset almost_full", 64'(almost_full), 64'(0));
    chk("reset overflow", 64'(overflow), 64'(0));
    chk("reset underflow", 64'(underflow), 64'(0));
`ifndef SYNC_FIFO_FWFT_EN
    chk("reset rd_data", 64'(rd_data), 64'(0));
`endif

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // reset asserted mid-operation with underflow set and words queued
    apply(mk(0, 0, '0, 1, 0, 0, '0, 0, 0, 1), 1000);
    for (int i = 1; i <= 3; i++) apply(mk(0, 1, DW'(96 + i), 0, 0, 0, '0, i, 0, 1), 1000 + i);
    rst_n = 1'b0;
    #1;
    chk("midreset level", 64'(level), 64'(0));
    chk("midreset empty", 64'(empty), 64'(1));
    chk("midreset underflow", 64'(underflow), 64'(0));
`ifndef SYNC_FIFO_FWFT_EN
    chk("midreset rd_data", 64'(rd_data), 64'(0));
`endif
    @(negedge clk);
    rst_n = 1'b1;
    last_pop = '0;
    @(negedge clk);
    v = mk(0, 1, DW'(90), 0, 0, 0, '0, 1, 0, 0);
    apply(v, 2000);
    v = mk(0, 0, '0, 1, 0, 1, DW'(90), 0, 0, 0);
    apply(v, 2001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
